// File: rtl/hash160_digest_collector.sv
// Reassembles the Hash160 core's streamed answer words into one digest,
// pulses o_done on completion and compares the result against a golden value.
module hash160_digest_collector #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 10,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  logic [WORD_W-1:0]           i_answer,
  input  logic [WORD_W*NUM_WORDS-1:0] i_expected,
  output logic [WORD_W*NUM_WORDS-1:0] o_digest,
  output logic                        o_done,
  output logic                        o_match,
  output logic                        o_busy,
  output logic                        o_overrun,
  output logic [CNT_W-1:0]            o_count
);

  localparam int DIG_W = WORD_W * NUM_WORDS;
  localparam int SH_W  = WORD_W * (NUM_WORDS - 1);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    S_IDLE,
    S_CAPTURE
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [SH_W-1:0]   r_shadow;
  logic              r_prev_valid;

  logic              w_last;
  logic              w_rise;
  logic [DIG_W-1:0]  w_full;
  logic [SH_W-1:0]   w_shift;

  assign w_last  = (r_idx == LAST_IDX);
  assign w_rise  = i_valid && !r_prev_valid;
  assign w_full  = {r_shadow, i_answer};
  // Shifting in from the LSB leaves word 0 in the MSBs after NUM_WORDS-1 words,
  // which is the same as indexed storage without a write decoder.
  assign w_shift = {r_shadow[SH_W-WORD_W-1:0], i_answer};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_prev_valid <= 1'b0;
      o_digest     <= '0;
      o_done       <= 1'b0;
      o_match      <= 1'b0;
      o_busy       <= 1'b0;
      o_overrun    <= 1'b0;
      o_count      <= '0;
    end else begin
      r_prev_valid <= i_valid;
      o_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_shadow <= w_shift;
            r_idx    <= IDX_W'(1);
            r_state  <= S_CAPTURE;
            o_busy   <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (w_rise) begin
            o_overrun <= 1'b1;
          end
          if (w_last) begin
            o_digest <= w_full;
            o_match  <= (w_full == i_expected);
            o_done   <= 1'b1;
            o_count  <= o_count + 1'b1;
            r_idx    <= '0;
            r_state  <= S_IDLE;
            o_busy   <= 1'b0;
          end else begin
            r_shadow <= w_shift;
            r_idx    <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hash160_digest_collector.md
Name: hash160_digest_collector

Overview:
Sink-side partner of the Hash160 core's result interface. When the core raises its output-valid strobe, this block captures the 16-bit answer words streamed on consecutive cycles and reassembles them into one 160-bit digest. It then pulses a completion flag and compares the digest against an expected value. It sits between the top's o_valid/o_answer pins and the host/readback logic, and serves as the self-check block in system benches.

Parameters:
WORD_W, 16, width of each answer word from the core
NUM_WORDS, 10, words per digest
CNT_W, 8, width of the completed-digest counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
i_valid  input  1  core o_valid; high in the cycle carrying word 0
i_answer  input  WORD_W  core o_answer stream
i_expected  input  WORD_W*NUM_WORDS  golden digest; sampled on the capture-completing edge
o_digest  output  WORD_W*NUM_WORDS  assembled digest; word 0 in the MSBs [159:144]
o_done  output  1  one-cycle pulse: o_digest and o_match updated
o_match  output  1  o_digest == sampled i_expected; valid when o_done is high, then held
o_busy  output  1  capture in progress
o_overrun  output  1  sticky: i_valid rose during a capture
o_count  output  CNT_W  completed digests, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, word index=0, o_digest=0, o_done=0, o_match=0, o_busy=0, o_overrun=0, o_count=0. Reset wins over every other event, including a capture in progress. Any partial digest is discarded, and o_digest returns to 0.
- States: IDLE, CAPTURE.
- IDLE: at an edge with i_valid=1, store i_answer as word 0 in a shadow register, set index=1, go to CAPTURE, and set o_busy=1.
- CAPTURE: every edge stores i_answer as word[index] and increments index. The level of i_valid is ignored; the core may hold it high or pulse it.
- Completing edge is the edge where index==NUM_WORDS-1, i.e. edge T0+9, counting the word-0 edge as T0. At that edge:
  - o_digest <= {shadow words 0..8, i_answer};
  - o_match <= (that value == i_expected);
  - o_done <= 1 for exactly one cycle;
  - o_count increments;
  - state returns to IDLE and o_busy drops.
- Total latency: o_done is high in the cycle after the 10th word, i.e. 10 cycles after the word-0 edge.
- The shadow register is separate from o_digest. o_digest changes only on completing edges and holds between them.
- Back-to-back: i_valid=1 in the cycle o_done is high is accepted as word 0 of a new digest. There is no dead cycle.
- Overrun: a rising edge of i_valid (0 in the previous cycle, 1 now) while in CAPTURE sets o_overrun. The current capture continues unchanged, and that word is taken as data. o_overrun is cleared only by rst. A level-held i_valid does not flag overrun.
- No backpressure: the core cannot be stalled, so the collector must accept every word.
- o_count wraps from 2^CNT_W-1 to 0 without a flag.
- i_expected needs to be stable only at the completing edge.

Test Plan:
- Reset, then i_valid pulse with words 0x0001..0x000A on consecutive cycles and i_expected = 0x0001_0002_..._000A -> o_done high exactly 10 cycles after the word-0 edge; o_digest=0x000100020003000400050006000700080009000A; o_match=1; o_count=1; o_busy high for 9 cycles.
- Same words with i_expected differing in the LSB -> o_done=1, o_match=0, o_digest as above; o_match holds 0 until the next completion.
- Two digests back-to-back, with the second word 0 presented in the o_done cycle (words 0xA000..0xA009) -> second o_done exactly 10 cycles after the first; o_count=2; o_overrun=0.
- i_valid held high across all 10 words -> single capture, o_overrun=0. Then i_valid pulsed 0->1 at word 5 of the next capture -> o_overrun=1 (sticky); that digest still completes with the streamed data.
- rst asserted at word 4 of a capture -> next cycle state IDLE, o_busy=0, o_digest=0, no o_done. A fresh 10-word burst afterwards completes correctly with o_count=1.
- 256 digests of 0xFFFF words -> o_count wraps to 0 with CNT_W=8; every o_digest is all ones.
